// File: rtl/fighter_player.sv
`default_nettype none
// ============================================================================
// Module   : fighter_player
// Purpose  : Combat state for one player. There is one instance per side.
//            It tracks the player's arena position and health. It resolves
//            incoming punches and kicks against the player's own guard. It
//            also handles collision blocking, slow healing while waiting, and
//            a sticky knockout latch.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            restart  - synchronous round restart (same effect as reset)
//            own_act  - own action, one-hot {FWD,BACK,WAIT,JUMP,KICK,PUNCH}
//            opp_act  - opponent action, same encoding
//            opp_loc  - opponent absolute location
//            loc      - own absolute location (registered)
//            health   - own health (registered)
//            ko       - sticky knockout flag
//            hit      - one-cycle pulse, damage applied
//            bad_act  - one-cycle pulse, own_act nonzero and not one-hot
// Revision : 1.0 - initial release
// ============================================================================
module fighter_player #(
  parameter int SIDE       = 0,
  parameter int ARENA_W    = 8,
  parameter int LOC_W      = 3,
  parameter int START_LOC  = 2,
  parameter int HP_MAX     = 3,
  parameter int HP_W       = 3,
  parameter int PUNCH_DMG  = 2,
  parameter int KICK_DMG   = 1,
  parameter int KICK_RANGE = 2,
  parameter int HEAL_WAIT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [5:0]       own_act,
  input  logic [5:0]       opp_act,
  input  logic [LOC_W-1:0] opp_loc,
  output logic [LOC_W-1:0] loc,
  output logic [HP_W-1:0]  health,
  output logic             ko,
  output logic             hit,
  output logic             bad_act
);

  localparam int c_cnt_w = (HEAL_WAIT < 1) ? 1 : $clog2(HEAL_WAIT + 1);

  localparam logic [LOC_W-1:0] c_start_loc  = LOC_W'(START_LOC);
  localparam logic [LOC_W-1:0] c_back_wall  = LOC_W'((SIDE == 0) ? 0 : ARENA_W - 1);
  localparam logic [LOC_W-1:0] c_front_wall = LOC_W'((SIDE == 0) ? ARENA_W - 1 : 0);
  localparam logic [HP_W-1:0]  c_hp_max     = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0]  c_punch_dmg  = HP_W'(PUNCH_DMG);
  localparam logic [HP_W-1:0]  c_kick_dmg   = HP_W'(KICK_DMG);
  localparam logic [LOC_W:0]   c_kick_range = (LOC_W + 1)'(KICK_RANGE);
  localparam logic [c_cnt_w-1:0] c_heal_last = c_cnt_w'(HEAL_WAIT - 1);

  typedef enum logic [0:0] {
    ST_FIGHT = 1'b0,
    ST_KO    = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [LOC_W-1:0]   r_loc, w_loc_nxt;
  logic [HP_W-1:0]    r_health, w_health_nxt;
  logic [c_cnt_w-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic               r_hit, w_hit_nxt;
  logic               r_bad_act, w_bad_act_nxt;

  // Action decode. A non-one-hot vector decodes to idle (all strobes low).
  logic w_own_onehot, w_opp_onehot;
  logic w_own_fwd, w_own_back, w_own_wait, w_own_jump, w_own_kick, w_own_punch;
  logic w_opp_kick, w_opp_punch;

  assign w_own_onehot = (|own_act) && ~|(own_act & (own_act - 6'd1));
  assign w_opp_onehot = (|opp_act) && ~|(opp_act & (opp_act - 6'd1));

  assign w_own_fwd   = w_own_onehot & own_act[5];
  assign w_own_back  = w_own_onehot & own_act[4];
  assign w_own_wait  = w_own_onehot & own_act[3];
  assign w_own_jump  = w_own_onehot & own_act[2];
  assign w_own_kick  = w_own_onehot & own_act[1];
  assign w_own_punch = w_own_onehot & own_act[0];
  assign w_opp_kick  = w_opp_onehot & opp_act[1];
  assign w_opp_punch = w_opp_onehot & opp_act[0];

  // Free cells between the two players. The extra bit keeps the
  // subtraction well defined. The two players never share a cell, so the
  // distance is always at least 1.
  logic [LOC_W:0] w_dist, w_gap;
  assign w_dist = (r_loc > opp_loc) ? ({1'b0, r_loc} - {1'b0, opp_loc})
                                    : ({1'b0, opp_loc} - {1'b0, r_loc});
  assign w_gap  = w_dist - 1'b1;

  logic w_gap0;
  assign w_gap0 = (w_gap == '0);

  // One-cell steps in either direction, relative to this player's facing.
  logic [LOC_W-1:0] w_step_fwd, w_step_back;
  assign w_step_fwd  = (SIDE == 0) ? r_loc + 1'b1 : r_loc - 1'b1;
  assign w_step_back = (SIDE == 0) ? r_loc - 1'b1 : r_loc + 1'b1;

  // Incoming attack resolution. Jumping dodges both attack types.
  logic            w_punch_in, w_kick_in, w_pushback, w_take_dmg;
  logic [HP_W-1:0] w_dmg;

  assign w_punch_in = w_opp_punch & w_gap0 & ~w_own_jump;
  assign w_kick_in  = w_opp_kick & (w_gap < c_kick_range) & ~w_own_jump;
  assign w_pushback = (w_punch_in & w_own_punch) | (w_kick_in & w_own_kick);

  always_comb begin
    w_take_dmg = 1'b0;
    w_dmg      = '0;
    if (w_punch_in && !w_own_punch) begin
      w_take_dmg = 1'b1;
      w_dmg      = c_punch_dmg;
    end else if (w_kick_in && !w_own_kick && !(w_own_punch && w_gap0)) begin
      // A punch at contact range stops a kick but does not push back.
      w_take_dmg = 1'b1;
      w_dmg      = c_kick_dmg;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_loc_nxt      = r_loc;
    w_health_nxt   = r_health;
    w_wait_cnt_nxt = r_wait_cnt;
    w_hit_nxt      = 1'b0;
    w_bad_act_nxt  = 1'b0;

    case (r_state)
      ST_FIGHT: begin
        w_bad_act_nxt = (|own_act) & ~w_own_onehot;

        // Pushback takes priority over the player's own movement.
        if (w_pushback) begin
          if (r_loc != c_back_wall) w_loc_nxt = w_step_back;
        end else if (w_own_fwd) begin
          if (!w_gap0 && r_loc != c_front_wall) w_loc_nxt = w_step_fwd;
        end else if (w_own_back) begin
          if (r_loc != c_back_wall) w_loc_nxt = w_step_back;
        end

        if (w_take_dmg) begin
          w_hit_nxt      = 1'b1;
          w_wait_cnt_nxt = '0;
          w_health_nxt   = (r_health > w_dmg) ? r_health - w_dmg : '0;
          if (w_health_nxt == '0) w_state_nxt = ST_KO;
        end else if (w_own_wait) begin
          if (r_wait_cnt == c_heal_last) begin
            w_wait_cnt_nxt = '0;
            if (r_health != c_hp_max) w_health_nxt = r_health + 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end else begin
          w_wait_cnt_nxt = '0;
        end
      end

      ST_KO: begin
        // Frozen until reset or restart. The defaults hold all state.
      end

      default: w_state_nxt = ST_FIGHT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FIGHT;
      r_loc      <= c_start_loc;
      r_health   <= c_hp_max;
      r_wait_cnt <= '0;
      r_hit      <= 1'b0;
      r_bad_act  <= 1'b0;
    end else if (restart) begin
      r_state    <= ST_FIGHT;
      r_loc      <= c_start_loc;
      r_health   <= c_hp_max;
      r_wait_cnt <= '0;
      r_hit      <= 1'b0;
      r_bad_act  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_loc      <= w_loc_nxt;
      r_health   <= w_health_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_hit      <= w_hit_nxt;
      r_bad_act  <= w_bad_act_nxt;
    end
  end

  assign loc     = r_loc;
  assign health  = r_health;
  assign ko      = (r_state == ST_KO);
  assign hit     = r_hit;
  assign bad_act = r_bad_act;

endmodule
`default_nettype wire

// File: tb/tb_fighter_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_fighter_player
// Purpose  : Self-checking bench for fighter_player with default parameters
//            (left side, start cell 2, health 3). For each stimulus cycle it
//            pushes the expected outputs onto a scoreboard queue. After the
//            clock edge it pops that entry and compares it with the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fighter_player;

  localparam logic [5:0] c_idle  = 6'b000000;
  localparam logic [5:0] c_fwd   = 6'b100000;
  localparam logic [5:0] c_back  = 6'b010000;
  localparam logic [5:0] c_wait  = 6'b001000;
  localparam logic [5:0] c_jump  = 6'b000100;
  localparam logic [5:0] c_kick  = 6'b000010;
  localparam logic [5:0] c_punch = 6'b000001;
  localparam logic [5:0] c_bad2  = 6'b000011;
  localparam logic [5:0] c_bad_m = 6'b110000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic [5:0] own_act;
  logic [5:0] opp_act;
  logic [2:0] opp_loc;
  logic [2:0] loc;
  logic [2:0] health;
  logic       ko;
  logic       hit;
  logic       bad_act;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] loc;
    logic [2:0] hp;
    logic       ko;
    logic       hit;
    logic       bad;
  } obs_t;

  typedef struct {
    logic       rs;
    logic [5:0] own;
    logic [5:0] opp;
    logic [2:0] oloc;
    obs_t       exp;
  } step_t;

  obs_t exp_q[$];

  fighter_player dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .own_act (own_act),
    .opp_act (opp_act),
    .opp_loc (opp_loc),
    .loc     (loc),
    .health  (health),
    .ko      (ko),
    .hit     (hit),
    .bad_act (bad_act)
  );

  always #5 clk = ~clk;

  function automatic step_t st(input logic rs, input logic [5:0] own, input logic [5:0] opp,
                               input logic [2:0] oloc, input logic [2:0] eloc,
                               input logic [2:0] ehp, input logic eko, input logic ehit,
                               input logic ebad);
    step_t s;
    s.rs   = rs;
    s.own  = own;
    s.opp  = opp;
    s.oloc = oloc;
    s.exp  = '{loc: eloc, hp: ehp, ko: eko, hit: ehit, bad: ebad};
    return s;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, and stop 1 time
  // unit after the capturing edge.
  task automatic apply(input step_t s);
    restart = s.rs;
    own_act = s.own;
    opp_act = s.opp;
    opp_loc = s.oloc;
    exp_q.push_back(s.exp);
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic test_reset;
    step_t tbl[$];
    obs_t  got, want;
    rst_n   = 1'b0;
    restart = 1'b0;
    own_act = c_idle;
    opp_act = c_idle;
    opp_loc = 3'd5;
    #12;
    got  = {loc, health, ko, hit, bad_act};
    want = '{loc: 3'd2, hp: 3'd3, ko: 1'b0, hit: 1'b0, bad: 1'b0};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", got, want);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tbl.push_back(st(0, c_idle, c_idle, 5, 2, 3, 0, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got  = {loc, health, ko, hit, bad_act};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset_idle[%0d] loc/hp/ko/hit/bad got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_move;
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(st(0, c_fwd,  c_idle, 5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,  c_idle, 5, 4, 3, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,  c_idle, 5, 4, 3, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,  c_idle, 5, 4, 3, 0, 0, 0));
    tbl.push_back(st(0, c_back, c_idle, 5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_back, c_idle, 5, 2, 3, 0, 0, 0));
    tbl.push_back(st(0, c_back, c_idle, 5, 1, 3, 0, 0, 0));
    tbl.push_back(st(0, c_back, c_idle, 5, 0, 3, 0, 0, 0));
    tbl.push_back(st(0, c_back, c_idle, 5, 0, 3, 0, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got  = {loc, health, ko, hit, bad_act};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL move[%0d] loc/hp/ko/hit/bad got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_punch_ko;
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(st(1, c_idle,  c_idle,  5, 2, 3, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,   c_idle,  5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,   c_idle,  5, 4, 3, 0, 0, 0));
    tbl.push_back(st(0, c_wait,  c_punch, 5, 4, 1, 0, 1, 0));
    tbl.push_back(st(0, c_idle,  c_idle,  5, 4, 1, 0, 0, 0));
    tbl.push_back(st(0, c_wait,  c_punch, 5, 4, 0, 1, 1, 0));
    tbl.push_back(st(0, c_back,  c_punch, 5, 4, 0, 1, 0, 0));
    tbl.push_back(st(0, c_bad2,  c_idle,  5, 4, 0, 1, 0, 0));
    tbl.push_back(st(0, c_wait,  c_idle,  5, 4, 0, 1, 0, 0));
    tbl.push_back(st(1, c_fwd,   c_idle,  5, 2, 3, 0, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got  = {loc, health, ko, hit, bad_act};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL punch_ko[%0d] loc/hp/ko/hit/bad got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_kick;
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(st(0, c_fwd,   c_idle, 5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_jump,  c_kick, 5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_kick,  c_kick, 5, 2, 3, 0, 0, 0));
    tbl.push_back(st(0, c_wait,  c_kick, 5, 2, 3, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,   c_idle, 5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_wait,  c_kick, 5, 3, 2, 0, 1, 0));
    tbl.push_back(st(0, c_punch, c_kick, 5, 3, 1, 0, 1, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got  = {loc, health, ko, hit, bad_act};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL kick[%0d] loc/hp/ko/hit/bad got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_heal;
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 1, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 2, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 2, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_kick, 5, 3, 2, 0, 1, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 2, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_kick, 5, 3, 1, 0, 1, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 1, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 2, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 2, 0, 0, 0));
    tbl.push_back(st(0, c_idle, c_idle, 5, 3, 2, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 2, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_idle, 5, 3, 3, 0, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got  = {loc, health, ko, hit, bad_act};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL heal[%0d] loc/hp/ko/hit/bad got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_guard_walls;
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(st(1, c_idle,  c_idle,  5, 2, 3, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,   c_idle,  5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,   c_idle,  5, 4, 3, 0, 0, 0));
    tbl.push_back(st(0, c_bad2,  c_idle,  5, 4, 3, 0, 0, 1));
    tbl.push_back(st(0, c_bad2,  c_punch, 5, 4, 1, 0, 1, 1));
    tbl.push_back(st(0, c_bad_m, c_idle,  5, 4, 1, 0, 0, 1));
    tbl.push_back(st(0, c_idle,  c_idle,  5, 4, 1, 0, 0, 0));
    tbl.push_back(st(0, c_punch, c_punch, 5, 3, 1, 0, 0, 0));
    tbl.push_back(st(0, c_back,  c_idle,  5, 2, 1, 0, 0, 0));
    tbl.push_back(st(0, c_back,  c_idle,  5, 1, 1, 0, 0, 0));
    tbl.push_back(st(0, c_back,  c_idle,  5, 0, 1, 0, 0, 0));
    tbl.push_back(st(0, c_punch, c_punch, 1, 0, 1, 0, 0, 0));
    tbl.push_back(st(0, c_punch, c_kick,  1, 0, 1, 0, 0, 0));
    tbl.push_back(st(0, c_kick,  c_kick,  1, 0, 1, 0, 0, 0));
    tbl.push_back(st(0, c_wait,  c_bad2,  1, 0, 1, 0, 0, 0));
    tbl.push_back(st(0, c_jump,  c_punch, 1, 0, 1, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,   c_idle,  1, 0, 1, 0, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got  = {loc, health, ko, hit, bad_act};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL guard_walls[%0d] loc/hp/ko/hit/bad got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back;
    step_t tbl[$];
    obs_t  got, want;
    // Move off the start cell, then pull the asynchronous reset mid-cycle.
    apply(st(0, c_fwd, c_idle, 5, 1, 1, 0, 0, 0));
    got  = {loc, health, ko, hit, bad_act};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL b2b_pre got=%b want=%b", got, want);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got  = {loc, health, ko, hit, bad_act};
    want = '{loc: 3'd2, hp: 3'd3, ko: 1'b0, hit: 1'b0, bad: 1'b0};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL async_reset got=%b want=%b", got, want);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tbl.push_back(st(0, c_fwd,  c_idle,  5, 3, 3, 0, 0, 0));
    tbl.push_back(st(0, c_fwd,  c_idle,  5, 4, 3, 0, 0, 0));
    tbl.push_back(st(0, c_wait, c_punch, 5, 4, 1, 0, 1, 0));
    tbl.push_back(st(0, c_wait, c_kick,  5, 4, 0, 1, 1, 0));
    tbl.push_back(st(0, c_idle, c_idle,  5, 4, 0, 1, 0, 0));
    tbl.push_back(st(1, c_idle, c_idle,  5, 2, 3, 0, 0, 0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got  = {loc, health, ko, hit, bad_act};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL b2b[%0d] loc/hp/ko/hit/bad got=%b want=%b", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_punch_ko();
    test_kick();
    test_heal();
    test_guard_walls();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
